// File: rtl/systolic_feeder.sv
// Edge feeder for an NxN systolic multiply array: buffers matrices A and B and
// streams them skewed onto the array's left edge (A rows) and top edge (B columns).
module systolic_feeder #(
    parameter int N = 4,
    parameter int W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic                    wr_sel,
    input  logic [2*$clog2(N)-1:0]  wr_addr,
    input  logic [W-1:0]            wr_data,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    array_rst,
    output logic [N*W-1:0]          a_edge,
    output logic [N*W-1:0]          b_edge
);

    localparam int AW = $clog2(N);
    localparam int CW = $clog2(2*N);
    localparam logic [CW-1:0] FEED_LAST  = CW'(2*N - 2);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(N - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [W-1:0]    a_mem [N][N];
    logic [W-1:0]    b_mem [N][N];

    logic [AW-1:0]   wr_row, wr_col;
    logic [N*W-1:0]  a_edge_d, b_edge_d;

    assign wr_row = wr_addr[2*AW-1:AW];
    assign wr_col = wr_addr[AW-1:0];

    // NOTE: the buffers must read as zero after rst, so every entry is a
    // resettable flop rather than a RAM macro.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    a_mem[r][c] <= '0;
                    b_mem[r][c] <= '0;
                end
            end
        end else if (state_q == IDLE && wr_en && int'(wr_row) < N && int'(wr_col) < N) begin
            if (wr_sel) begin
                b_mem[wr_row][wr_col] <= wr_data;
            end else begin
                a_mem[wr_row][wr_col] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: defaults first keeps every path assigned, so no latches are inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                cnt_d   = '0;
                state_d = FEED;
            end
            FEED: begin
                if (cnt_q == FEED_LAST) begin
                    cnt_d   = '0;
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Row i / column i carries diagonal element t-i; outside the diagonal band it is zero.
    always_comb begin
        a_edge_d = '0;
        b_edge_d = '0;
        if (state_q == FEED) begin
            for (int i = 0; i < N; i++) begin
                if (int'(cnt_q) >= i && int'(cnt_q) - i < N) begin
                    a_edge_d[i*W +: W] = a_mem[AW'(i)][AW'(int'(cnt_q) - i)];
                    b_edge_d[i*W +: W] = b_mem[AW'(int'(cnt_q) - i)][AW'(i)];
                end
            end
        end
    end

    // Pulses and edge buses are registered from the current state, so they
    // appear one cycle after the state that produces them; the PE grid sees
    // its last operand pair on the edge before done rises.
    always_ff @(posedge clk) begin
        if (rst) begin
            array_rst <= 1'b0;
            done      <= 1'b0;
            a_edge    <= '0;
            b_edge    <= '0;
        end else begin
            array_rst <= (state_q == CLEAR);
            done      <= (state_q == DONE);
            a_edge    <= a_edge_d;
            b_edge    <= b_edge_d;
        end
    end

    assign busy = (state_q != IDLE);

endmodule
